ir_cmd_sequencer: RTL and testbench
===================================

// Module: ir_cmd_sequencer
// PURPOSE
//  Sits between the NEC IR frame decoder and the application logic. Qualifies each decoded 32-bit
//  frame (customer code, key/~key check), classifies it as new press or auto-repeat, throttles repeats,
//  and queues key commands in a 4-entry FIFO drained by a valid/ready handshake. Tracks key-held state.
// PARAMETERS
//  ADDR         16'hFF00    required customer code, frame bits [15:0]
//  FILTER_EN    1           1: drop frames whose [15:0] != ADDR; 0: accept any customer code
//  HOLD_CYCLES  6_000_000   hold window in iCLK cycles (120 ms at 50 MHz); also repeat window
//  HOLD_W       23          width of the hold timer; must satisfy HOLD_CYCLES < 2**HOLD_W
//  REPEAT_DIV   3           emit every REPEAT_DIV-th repeat frame (1 = emit all repeats)
// PORTS
//  iCLK          in   1   system clock, 50 MHz
//  iRST_n        in   1   asynchronous, active-low reset
//  iDATA_READY   in   1   decoder frame-ready level; may stay high for many cycles
//  iDATA         in   32  decoded frame: [31:24] ~key, [23:16] key, [15:0] customer code
//  iENABLE       in   1   1: accept frames; 0: ignore new frames (FIFO still drains)
//  oCMD_VALID    out  1   FIFO head valid
//  iCMD_READY    in   1   consumer accepts the head word
//  oCMD_KEY      out  8   head key code
//  oCMD_REPEAT   out  1   head is an auto-repeat (0 = first press)
//  oKEY_HELD     out  1   hold timer nonzero
//  oFIFO_LEVEL   out  3   FIFO occupancy, 0..4
//  oDROP_CNT     out  8   saturating count of FIFO-full drops
//  oREJECT_CNT   out  8   saturating count of address/complement rejects
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, hold timer 0, last_key invalid, repeat counter 0, FSM IDLE.
//  - iDATA_READY is registered twice; frame event = rise (d1 & ~d2). Edge ignored if iENABLE=0.
//  - FSM IDLE -> CAPTURE (on event) -> CHECK -> CLASSIFY -> IDLE; one cycle per state.
//    CAPTURE: latch iDATA. Edge events during CAPTURE/CHECK/CLASSIFY are discarded.
//  - CHECK: reject if [31:24] != ~[23:16], or FILTER_EN=1 and [15:0] != ADDR.
//    On reject: oREJECT_CNT++ (saturates at 255), hold timer and last_key untouched, go IDLE.
//  - CLASSIFY: repeat = last_key valid & key == last_key & timer != 0.
//    New press: push {0,key}; rep_cnt <= 0. Repeat: rep_cnt++; push {1,key} when rep_cnt+1 == REPEAT_DIV,
//    then rep_cnt <= 0; otherwise no push. On both, last_key <= key and timer <= HOLD_CYCLES.
//  - Hold timer decrements by 1 each cycle while nonzero. On reaching 0, last_key becomes invalid.
//    A reload in the same cycle as the final decrement wins; the timer is set to HOLD_CYCLES.
//  - oKEY_HELD = (timer != 0). It is registered and rises the cycle after CLASSIFY.
//  - FIFO: show-ahead, 4 x 9 bits. oCMD_VALID = level != 0. Head stays stable while valid & ~ready.
//    Pop on oCMD_VALID & iCMD_READY.
//  - Push when full: word dropped, oDROP_CNT++ (saturates at 255). Exception: a pop in the same cycle
//    frees a slot, so the push is accepted and the level stays 4.
//  - Push and pop together when not full: level unchanged. Pointers are 2-bit and wrap modulo 4.
//  - Latency: decoder-ready rise -> oCMD_VALID is 6 cycles with the FIFO previously empty
//    (2 sync + CAPTURE + CHECK + CLASSIFY + write).
//  - iENABLE low mid-frame: an FSM already past IDLE completes normally.
//  - Reset asserted mid-operation: immediate return to reset values; FIFO contents are lost.
// TESTING
//  1 Frame 32'hE718_FF00 -> after 6 cycles oCMD_VALID=1, oCMD_KEY=8'h18, oCMD_REPEAT=0;
//    iCMD_READY=1 -> level 0.
//  2 Frame 32'hE718_FF01 (bad addr), then 32'hE618_FF00 (bad complement) -> no push, oREJECT_CNT=2;
//    with FILTER_EN=0 the first frame is accepted.
//  3 Frame 32'hE718_FF00 sent 7 times, 1 ms apart, READY held low -> queue holds
//    {0,18},{1,18},{1,18}; oKEY_HELD=1.
//    Wait HOLD_CYCLES+2 cycles -> oKEY_HELD=0; next identical frame queued as new press (REPEAT=0).
//  4 Six distinct keys 8'h01..8'h06, READY low -> level 4, oDROP_CNT=2, head key 8'h01.
//    Then push while popping at full -> accepted, level stays 4.
//  5 Hold iDATA_READY high for 1000 cycles -> exactly one push. iENABLE=0 during a rise -> no push,
//    no reject count.
//  6 Pulse iRST_n low with FIFO level 3 and oKEY_HELD=1 -> all outputs 0 in the same cycle.
//    First frame after release is queued with REPEAT=0.

Source files
------------

// File: rtl/ir_cmd_sequencer.sv
// ir_cmd_sequencer: qualifies decoded NEC IR frames, classifies them as new
// presses or auto-repeats, throttles repeats and queues key commands in a
// 4-deep show-ahead FIFO drained by a valid/ready handshake.
module ir_cmd_sequencer #(
   parameter logic [15:0] ADDR        = 16'hFF00,
   parameter bit          FILTER_EN   = 1'b1,
   parameter int          HOLD_CYCLES = 6_000_000,
   parameter int          HOLD_W      = 23,
   parameter int          REPEAT_DIV  = 3
) (
   input  logic        iCLK,
   input  logic        iRST_n,
   input  logic        iDATA_READY,
   input  logic [31:0] iDATA,
   input  logic        iENABLE,
   output logic        oCMD_VALID,
   input  logic        iCMD_READY,
   output logic [7:0]  oCMD_KEY,
   output logic        oCMD_REPEAT,
   output logic        oKEY_HELD,
   output logic [2:0]  oFIFO_LEVEL,
   output logic [7:0]  oDROP_CNT,
   output logic [7:0]  oREJECT_CNT
);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_CHECK, S_CLASSIFY} state_t;

   state_t            state, state_nxt;
   logic              rdy_p0, rdy_p1;
   logic              frame_evt;
   logic [31:0]       frame_p0;
   logic              frame_bad;
   logic [7:0]        key;
   logic [HOLD_W-1:0] timer, timer_nxt;
   logic              last_vld;
   logic [7:0]        last_key;
   logic [7:0]        rep_cnt;
   logic              is_rep, rep_emit, push_nxt, load;
   logic              push_p1;
   logic [8:0]        push_word_p1;
   logic [8:0]        mem [4];
   logic [1:0]        wr_ptr, rd_ptr;
   logic [2:0]        level;
   logic              full, pop, wr_en, drop;
   logic [8:0]        head;

   // Saturating 8-bit increment for the event counters.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Two-flop synchroniser on the decoder ready level; only its rise is an event.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         rdy_p0 <= 1'b0;
         rdy_p1 <= 1'b0;
      end else begin
         rdy_p0 <= iDATA_READY;
         rdy_p1 <= rdy_p0;
      end
   end

   assign frame_evt = rdy_p0 & ~rdy_p1 & iENABLE;

   // FSM state register.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) state <= S_IDLE;
      else         state <= state_nxt;
   end

   // Next-state logic; events arriving outside IDLE are simply not looked at.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (frame_evt) state_nxt = S_CAPTURE;
         S_CAPTURE:  state_nxt = S_CHECK;
         S_CHECK:    state_nxt = frame_bad ? S_IDLE : S_CLASSIFY;
         S_CLASSIFY: state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Frame capture register (data only, no reset needed).
   always_ff @(posedge iCLK) begin
      if (state == S_CAPTURE) frame_p0 <= iDATA;
   end

   assign key       = frame_p0[23:16];
   assign frame_bad = (frame_p0[31:24] != ~frame_p0[23:16]) ||
                      (FILTER_EN && (frame_p0[15:0] != ADDR));

   // Count rejected frames, saturating.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n)                            oREJECT_CNT <= 8'd0;
      else if (state == S_CHECK && frame_bad) oREJECT_CNT <= sat_inc8(oREJECT_CNT);
   end

   // Classification: repeat detection, repeat throttling, hold-timer reload.
   always_comb begin
      load     = (state == S_CLASSIFY);
      is_rep   = last_vld && (key == last_key) && (timer != '0);
      rep_emit = is_rep && ((rep_cnt + 8'd1) == 8'(REPEAT_DIV));
      push_nxt = load && (!is_rep || rep_emit);
      if (load)                timer_nxt = HOLD_W'(HOLD_CYCLES);
      else if (timer != '0)    timer_nxt = timer - HOLD_W'(1);
      else                     timer_nxt = timer;
   end

   // Hold timer, key-held flag, last-key validity and repeat counter.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         timer     <= '0;
         oKEY_HELD <= 1'b0;
         last_vld  <= 1'b0;
         rep_cnt   <= 8'd0;
         push_p1   <= 1'b0;
      end else begin
         timer     <= timer_nxt;
         oKEY_HELD <= (timer_nxt != '0);
         last_vld  <= (timer_nxt != '0);
         push_p1   <= push_nxt;
         if (load) rep_cnt <= (!is_rep || rep_emit) ? 8'd0 : rep_cnt + 8'd1;
      end
   end

   // Last key and the word handed to the FIFO write stage (data only).
   always_ff @(posedge iCLK) begin
      if (load) begin
         last_key     <= key;
         push_word_p1 <= {is_rep, key};
      end
   end

   assign full  = (level == 3'd4);
   assign pop   = (level != 3'd0) && iCMD_READY;
   assign wr_en = push_p1 && (!full || pop);
   assign drop  = push_p1 && full && !pop;

   // FIFO storage.
   always_ff @(posedge iCLK) begin
      if (wr_en) mem[wr_ptr] <= push_word_p1;
   end

   // FIFO pointers, occupancy and drop counter.
   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         wr_ptr    <= 2'd0;
         rd_ptr    <= 2'd0;
         level     <= 3'd0;
         oDROP_CNT <= 8'd0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 2'd1;
         if (pop)   rd_ptr <= rd_ptr + 2'd1;
         case ({wr_en, pop})
            2'b10:   level <= level + 3'd1;
            2'b01:   level <= level - 3'd1;
            default: level <= level;
         endcase
         if (drop) oDROP_CNT <= sat_inc8(oDROP_CNT);
      end
   end

   // Head word is masked while empty so stale storage never shows on the outputs.
   assign head        = mem[rd_ptr];
   assign oCMD_VALID  = (level != 3'd0);
   assign oCMD_KEY    = oCMD_VALID ? head[7:0] : 8'd0;
   assign oCMD_REPEAT = oCMD_VALID ? head[8]   : 1'b0;
   assign oFIFO_LEVEL = level;

endmodule

// File: tb/tb_ir_cmd_sequencer.sv
// Self-checking bench for ir_cmd_sequencer: directed frames, scoreboard queue
// filled at stimulus time and drained by an independent handshake monitor.
module tb_ir_cmd_sequencer;

   localparam int HOLD = 200;

   logic        iCLK = 1'b0;
   logic        iRST_n = 1'b0;
   logic        iDATA_READY = 1'b0;
   logic [31:0] iDATA = 32'd0;
   logic        iENABLE = 1'b1;
   logic        iCMD_READY = 1'b0;

   logic        oCMD_VALID, oCMD_REPEAT, oKEY_HELD;
   logic [7:0]  oCMD_KEY, oDROP_CNT, oREJECT_CNT;
   logic [2:0]  oFIFO_LEVEL;

   logic        nf_valid, nf_repeat, nf_held;
   logic [7:0]  nf_key, nf_drop, nf_rej;
   logic [2:0]  nf_level;

   int          checks = 0;
   int          failures = 0;
   logic [8:0]  exp_q [$];
   logic [8:0]  exp_w;

   ir_cmd_sequencer #(.ADDR(16'hFF00), .FILTER_EN(1'b1), .HOLD_CYCLES(HOLD),
                      .HOLD_W(8), .REPEAT_DIV(3)) dut (
      .iCLK(iCLK), .iRST_n(iRST_n), .iDATA_READY(iDATA_READY), .iDATA(iDATA),
      .iENABLE(iENABLE), .oCMD_VALID(oCMD_VALID), .iCMD_READY(iCMD_READY),
      .oCMD_KEY(oCMD_KEY), .oCMD_REPEAT(oCMD_REPEAT), .oKEY_HELD(oKEY_HELD),
      .oFIFO_LEVEL(oFIFO_LEVEL), .oDROP_CNT(oDROP_CNT), .oREJECT_CNT(oREJECT_CNT));

   ir_cmd_sequencer #(.ADDR(16'hFF00), .FILTER_EN(1'b0), .HOLD_CYCLES(HOLD),
                      .HOLD_W(8), .REPEAT_DIV(3)) dut_nf (
      .iCLK(iCLK), .iRST_n(iRST_n), .iDATA_READY(iDATA_READY), .iDATA(iDATA),
      .iENABLE(iENABLE), .oCMD_VALID(nf_valid), .iCMD_READY(iCMD_READY),
      .oCMD_KEY(nf_key), .oCMD_REPEAT(nf_repeat), .oKEY_HELD(nf_held),
      .oFIFO_LEVEL(nf_level), .oDROP_CNT(nf_drop), .oREJECT_CNT(nf_rej));

   always #5 iCLK = ~iCLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge iCLK);
      #1;
   endtask

   function automatic logic [31:0] mk(input logic [7:0] k);
      return {~k, k, 16'hFF00};
   endfunction

   task automatic send(input logic [31:0] d, input int hi, input int lo);
      iDATA       = d;
      iDATA_READY = 1'b1;
      tick(hi);
      iDATA_READY = 1'b0;
      tick(lo);
   endtask

   task automatic drain(input int n);
      iCMD_READY = 1'b1;
      tick(n);
      iCMD_READY = 1'b0;
   endtask

   // Scoreboard monitor: every accepted head word is compared against the queue.
   always @(negedge iCLK) begin
      if (iRST_n && oCMD_VALID && iCMD_READY) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%0h expected=none", {oCMD_REPEAT, oCMD_KEY});
         end else begin
            exp_w = exp_q.pop_front();
            chk("sb_word", 32'({oCMD_REPEAT, oCMD_KEY}), 32'(exp_w));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      tick(3);
      chk("rst_valid", 32'(oCMD_VALID), 32'd0);
      chk("rst_level", 32'(oFIFO_LEVEL), 32'd0);
      chk("rst_held",  32'(oKEY_HELD), 32'd0);
      chk("rst_cnts",  32'({oDROP_CNT, oREJECT_CNT}), 32'd0);
      iRST_n = 1'b1;
      tick(2);

      // 1: single frame, 6-cycle latency, pop
      exp_q.push_back({1'b0, 8'h18});
      iDATA = 32'hE718_FF00;
      iDATA_READY = 1'b1;
      tick(5);
      chk("t1_valid_early", 32'(oCMD_VALID), 32'd0);
      tick(1);
      chk("t1_valid", 32'(oCMD_VALID), 32'd1);
      chk("t1_key", 32'(oCMD_KEY), 32'h18);
      chk("t1_repeat", 32'(oCMD_REPEAT), 32'd0);
      iDATA_READY = 1'b0;
      drain(1);
      chk("t1_level", 32'(oFIFO_LEVEL), 32'd0);
      tick(HOLD + 10);

      // 2: bad address, bad complement; unfiltered instance accepts the first
      send(32'hE718_FF01, 5, 20);
      send(32'hE618_FF00, 5, 20);
      chk("t2_level", 32'(oFIFO_LEVEL), 32'd0);
      chk("t2_reject", 32'(oREJECT_CNT), 32'd2);
      chk("t2_nf_level", 32'(nf_level), 32'd1);
      chk("t2_nf_key", 32'(nf_key), 32'h18);
      chk("t2_nf_reject", 32'(nf_rej), 32'd1);
      drain(1);
      chk("t2_nf_drained", 32'(nf_level), 32'd0);
      tick(HOLD + 10);

      // 3: seven identical frames -> press plus two throttled repeats
      exp_q.push_back({1'b0, 8'h18});
      exp_q.push_back({1'b1, 8'h18});
      exp_q.push_back({1'b1, 8'h18});
      repeat (7) send(mk(8'h18), 10, 30);
      chk("t3_level", 32'(oFIFO_LEVEL), 32'd3);
      chk("t3_held", 32'(oKEY_HELD), 32'd1);
      tick(HOLD + 2);
      chk("t3_released", 32'(oKEY_HELD), 32'd0);
      exp_q.push_back({1'b0, 8'h18});
      send(mk(8'h18), 10, 30);
      chk("t3_level4", 32'(oFIFO_LEVEL), 32'd4);
      drain(6);
      chk("t3_drained", 32'(oFIFO_LEVEL), 32'd0);

      // 4: overflow, then push accepted together with a pop at full
      for (int k = 1; k <= 6; k++) begin
         if (k <= 4) exp_q.push_back({1'b0, 8'(k)});
         send(mk(8'(k)), 5, 15);
      end
      chk("t4_level", 32'(oFIFO_LEVEL), 32'd4);
      chk("t4_drop", 32'(oDROP_CNT), 32'd2);
      chk("t4_head", 32'(oCMD_KEY), 32'h01);
      exp_q.push_back({1'b0, 8'h07});
      iDATA = mk(8'h07);
      iDATA_READY = 1'b1;
      tick(5);
      iCMD_READY = 1'b1;
      tick(1);
      iCMD_READY = 1'b0;
      iDATA_READY = 1'b0;
      chk("t4_level_full_pp", 32'(oFIFO_LEVEL), 32'd4);
      chk("t4_drop_full_pp", 32'(oDROP_CNT), 32'd2);
      chk("t4_head2", 32'(oCMD_KEY), 32'h02);
      tick(10);
      drain(6);
      chk("t4_drained", 32'(oFIFO_LEVEL), 32'd0);

      // 5: long ready level gives one push; disabled rise gives nothing
      exp_q.push_back({1'b0, 8'h20});
      send(mk(8'h20), 1000, 10);
      chk("t5_one_push", 32'(oFIFO_LEVEL), 32'd1);
      drain(2);
      iENABLE = 1'b0;
      send(mk(8'h21), 20, 5);
      iENABLE = 1'b1;
      tick(10);
      chk("t5_disabled_level", 32'(oFIFO_LEVEL), 32'd0);
      chk("t5_disabled_reject", 32'(oREJECT_CNT), 32'd2);

      // 6: asynchronous reset mid-operation
      exp_q.push_back({1'b0, 8'h30});
      exp_q.push_back({1'b0, 8'h31});
      exp_q.push_back({1'b0, 8'h32});
      send(mk(8'h30), 5, 15);
      send(mk(8'h31), 5, 15);
      send(mk(8'h32), 5, 15);
      chk("t6_pre_level", 32'(oFIFO_LEVEL), 32'd3);
      chk("t6_pre_held", 32'(oKEY_HELD), 32'd1);
      iRST_n = 1'b0;
      #1;
      exp_q.delete();
      chk("t6_rst_valid", 32'(oCMD_VALID), 32'd0);
      chk("t6_rst_level", 32'(oFIFO_LEVEL), 32'd0);
      chk("t6_rst_held", 32'(oKEY_HELD), 32'd0);
      chk("t6_rst_keyrep", 32'({oCMD_REPEAT, oCMD_KEY}), 32'd0);
      chk("t6_rst_cnts", 32'({oDROP_CNT, oREJECT_CNT}), 32'd0);
      tick(2);
      iRST_n = 1'b1;
      tick(2);
      exp_q.push_back({1'b0, 8'h32});
      send(mk(8'h32), 5, 15);
      chk("t6_post_level", 32'(oFIFO_LEVEL), 32'd1);
      chk("t6_post_repeat", 32'(oCMD_REPEAT), 32'd0);
      drain(2);
      chk("t6_drained", 32'(oFIFO_LEVEL), 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
